// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode and state encodings for the iterative shift unit
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter, moves a value by a small amount in one of four modes
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic [WIDTH-1:0] value,
  input  logic [AMT_W-1:0] amt,
  input  shift_mode_e      mode,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] shifted;

  // SRA and ROL go through a double-width vector so the fill/wrap bits come along for free
  always_comb begin
    ext     = '0;
    shifted = '0;
    result  = value;
    case (mode)
      MODE_SLL: result = value << amt;
      MODE_SRL: result = value >> amt;
      MODE_SRA: begin
        ext     = {{WIDTH{fill}}, value};
        shifted = ext >> amt;
        result  = shifted[WIDTH-1:0];
      end
      MODE_ROL: begin
        ext     = {value, value};
        shifted = ext << amt;
        result  = shifted[2*WIDTH-1:WIDTH];
      end
      default: result = value;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multi-cycle shift unit, up to STEP positions per clock, valid/ready on both sides
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         mode_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   data_o
);

  // one extra bit so STEP == WIDTH is representable
  localparam int AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP_V = AMT_W'(STEP);

  shift_state_e       state_q, state_d;
  shift_mode_e        mode_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] rem_q;
  logic               fill_q;

  logic [AMT_W-1:0]   rem_ext;
  logic [AMT_W-1:0]   step_amt;
  logic [SHAMT_W-1:0] rem_after;
  logic [WIDTH-1:0]   step_result;

  // step_amt never exceeds rem_q, so the truncation below is lossless
  assign rem_ext   = {1'b0, rem_q};
  assign step_amt  = (rem_ext < STEP_V) ? rem_ext : STEP_V;
  assign rem_after = rem_q - step_amt[SHAMT_W-1:0];

  shift_step #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) u_step (
    .value (work_q),
    .amt   (step_amt),
    .mode  (mode_q),
    .fill  (fill_q),
    .result(step_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (in_valid_i) state_d = (shamt_i == '0) ? ST_DONE : ST_SHIFT;
        ST_SHIFT: if (rem_after == '0) state_d = ST_DONE;
        ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_DONE);
  end

  assign data_o = work_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q <= '0;
      rem_q  <= '0;
      mode_q <= MODE_SLL;
      fill_q <= 1'b0;
    end else if (flush_i) begin
      rem_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            work_q <= data_i;
            rem_q  <= shamt_i;
            mode_q <= shift_mode_e'(mode_i);
            fill_q <= data_i[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          work_q <= step_result;
          rem_q  <= rem_after;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - directed self-checking bench for shift_unit_seq at WIDTH=32, STEP=4
module tb_shift_unit_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic [1:0]  mode_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .data_i     (data_i),
    .shamt_i    (shamt_i),
    .mode_i     (mode_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .data_o     (data_o)
  );

  always #5 clk_i = ~clk_i;

  // drive a request at a negedge; returns 1 ns after the accepting edge with the inputs scrambled
  task automatic accept(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m);
    @(negedge clk_i);
    in_valid_i = 1'b1;
    data_i     = d;
    shamt_i    = sh;
    mode_i     = m;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    data_i     = 32'h5A5A_C3C3;
    shamt_i    = 5'd3;
    mode_i     = 2'b01;
  endtask

  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid_o && edges < 40) begin
      @(posedge clk_i);
      #1;
      edges++;
    end
  endtask

  task automatic release_result();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", data_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_sll();
    int e;
    accept(32'h0000_0001, 5'd2, 2'b00);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 2) begin n_fail++; $display("FAIL sll2_latency: got valid=%b edges=%0d want valid=1 edges=2", out_valid_o, e); end
    n_checks++; if (data_o !== 32'h0000_0004) begin n_fail++; $display("FAIL sll2_data: got %h want 00000004", data_o); end
    release_result();
    n_checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL sll2_release: got ready=%b valid=%b want 1 0", in_ready_o, out_valid_o); end
    accept(32'hDEAD_BEEF, 5'd2, 2'b00);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || data_o !== 32'h7AB6_FBBC) begin n_fail++; $display("FAIL sll2_legacy: got %h want 7ab6fbbc", data_o); end
    release_result();
  endtask

  task automatic test_sra_srl();
    int e;
    accept(32'h8000_0000, 5'd31, 2'b10);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 9) begin n_fail++; $display("FAIL sra31_latency: got valid=%b edges=%0d want valid=1 edges=9", out_valid_o, e); end
    n_checks++; if (data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra31_data: got %h want ffffffff", data_o); end
    release_result();
    accept(32'h8000_0000, 5'd31, 2'b01);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 9) begin n_fail++; $display("FAIL srl31_latency: got valid=%b edges=%0d want valid=1 edges=9", out_valid_o, e); end
    n_checks++; if (data_o !== 32'h0000_0001) begin n_fail++; $display("FAIL srl31_data: got %h want 00000001", data_o); end
    release_result();
    accept(32'h7000_0000, 5'd7, 2'b10);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 3 || data_o !== 32'h00E0_0000) begin n_fail++; $display("FAIL sra7_pos: got %h edges=%0d want 00e00000 edges=3", data_o, e); end
    release_result();
  endtask

  task automatic test_rol();
    int e;
    accept(32'h8000_0001, 5'd5, 2'b11);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 3) begin n_fail++; $display("FAIL rol5_latency: got valid=%b edges=%0d want valid=1 edges=3", out_valid_o, e); end
    n_checks++; if (data_o !== 32'h0000_0030) begin n_fail++; $display("FAIL rol5_data: got %h want 00000030", data_o); end
    release_result();
  endtask

  task automatic test_backpressure();
    int e;
    int bad;
    accept(32'h0000_00A5, 5'd4, 2'b00);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || data_o !== 32'h0000_0A50) begin n_fail++; $display("FAIL bp_first: got valid=%b data=%h want 1 00000a50", out_valid_o, data_o); end
    in_valid_i = 1'b1;
    data_i     = 32'h0000_0003;
    shamt_i    = 5'd1;
    mode_i     = 2'b00;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o !== 1'b1 || data_o !== 32'h0000_0A50 || in_ready_o !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    n_checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got ready=%b valid=%b want 1 0", in_ready_o, out_valid_o); end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 2 || data_o !== 32'h0000_0006) begin n_fail++; $display("FAIL bp_next: got %h edges=%0d want 00000006 edges=2", data_o, e); end
    release_result();
  endtask

  task automatic test_shamt0_flush();
    int e;
    int seen;
    accept(32'h1234_5678, 5'd0, 2'b10);
    e = 1;
    n_checks++; if (out_valid_o !== 1'b1 || data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL shamt0: got valid=%b data=%h want 1 12345678 after 1 edge", out_valid_o, data_o); end
    release_result();
    accept(32'h0000_0001, 5'd31, 2'b00);
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    n_checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_shift: got ready=%b valid=%b want 1 0", in_ready_o, out_valid_o); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    @(negedge clk_i);
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    data_i     = 32'h0000_0001;
    shamt_i    = 5'd0;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    n_checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_priority: got ready=%b valid=%b want 1 0", in_ready_o, out_valid_o); end
  endtask

  task automatic test_async_reset();
    accept(32'hFFFF_0000, 5'd31, 2'b01);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || data_o !== 32'h0) begin n_fail++; $display("FAIL async_reset: got valid=%b ready=%b data=%h want 0 1 00000000", out_valid_o, in_ready_o, data_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e;
    int t0;
    int t1;
    t0 = 0;
    accept(32'h0000_000F, 5'd8, 2'b11);
    wait_valid(e);
    n_checks++; if (out_valid_o !== 1'b1 || e != 3 || data_o !== 32'h0000_0F00) begin n_fail++; $display("FAIL b2b_first: got %h edges=%0d want 00000f00 edges=3", data_o, e); end
    release_result();
    accept(32'hF000_0000, 5'd9, 2'b11);
    wait_valid(e);
    t1 = e;
    n_checks++; if (out_valid_o !== 1'b1 || t1 != 4 || data_o !== 32'h0000_01E0) begin n_fail++; $display("FAIL b2b_second: got %h edges=%0d want 000001e0 edges=4", data_o, t1); end
    release_result();
    n_checks++; if (t0 != 0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got ready=%b want 1", in_ready_o); end
  endtask

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    data_i      = '0;
    shamt_i     = '0;
    mode_i      = 2'b00;
    out_ready_i = 1'b0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_rol();
    test_backpressure();
    test_shamt0_flush();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
